// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_modes_pkg / video_timing_gen
//
// Purpose:
//   video_modes_pkg describes a display mode: resolution, porches, sync widths,
//   sync polarities and the pixel clock it expects.
//   video_timing_gen turns one of those modes into the raster timing for the
//   display output stage. It also produces a lead "fetch" coordinate stream
//   that runs FETCH_LEAD cycles ahead of x/y/de, so an upstream pixel source
//   can issue reads early.
//
// Ports (all synchronous to clk, the mode's pixel clock):
//   clk          in   pixel clock
//   rst          in   synchronous, active-high reset (priority over en)
//   en           in   count enable; when 0 every counter and output holds
//   hsync        out  horizontal sync at the mode's polarity
//   vsync        out  vertical sync at the mode's polarity
//   de           out  active-video data enable
//   x, y         out  active pixel column/row, 0 when de=0
//   line_start   out  pulse on the first active pixel of each active line
//   frame_start  out  pulse on pixel (0,0)
//   fetch_valid  out  the position FETCH_LEAD cycles ahead is active
//   fetch_x/y    out  column/row of that lead position, 0 when not valid
//
// Every output is registered from the counter state of the previous cycle,
// so all outputs share a fixed latency of one enabled cycle.
// -----------------------------------------------------------------------------

package video_modes_pkg;

    typedef struct packed {
        logic [31:0] pclk_khz;
    } clock_config_t;

    typedef struct packed {
        clock_config_t clock_config;
        logic [15:0]   h_res;
        logic [15:0]   h_fp;
        logic [15:0]   h_sync;
        logic [15:0]   h_bp;
        logic [15:0]   v_res;
        logic [15:0]   v_fp;
        logic [15:0]   v_sync;
        logic [15:0]   v_bp;
        logic          h_sync_pol;  // level of hsync while the sync pulse is active
        logic          v_sync_pol;
    } video_mode_t;

    localparam video_mode_t VMODE_640x480p60 = '{
        clock_config: '{pclk_khz: 32'd25175},
        h_res: 16'd640, h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
        v_res: 16'd480, v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33,
        h_sync_pol: 1'b0, v_sync_pol: 1'b0
    };

    localparam video_mode_t VMODE_800x600p60 = '{
        clock_config: '{pclk_khz: 32'd40000},
        h_res: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
        v_res: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23,
        h_sync_pol: 1'b1, v_sync_pol: 1'b1
    };

endpackage

module video_timing_gen
    import video_modes_pkg::*;
#(
    parameter video_mode_t VIDEO_MODE = VMODE_640x480p60,
    parameter int          COORD_W    = 12,
    parameter int          FETCH_LEAD = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start,
    output logic               fetch_valid,
    output logic [COORD_W-1:0] fetch_x,
    output logic [COORD_W-1:0] fetch_y
);

    localparam int H_RES   = int'(VIDEO_MODE.h_res);
    localparam int H_FP    = int'(VIDEO_MODE.h_fp);
    localparam int H_SYNC  = int'(VIDEO_MODE.h_sync);
    localparam int H_BP    = int'(VIDEO_MODE.h_bp);
    localparam int V_RES   = int'(VIDEO_MODE.v_res);
    localparam int V_FP    = int'(VIDEO_MODE.v_fp);
    localparam int V_SYNC  = int'(VIDEO_MODE.v_sync);
    localparam int V_BP    = int'(VIDEO_MODE.v_bp);
    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    // Comparisons are done one bit wider than the counters so that window
    // ends equal to 2^COORD_W (zero back porch at full range) stay exact.
    localparam int CW1 = COORD_W + 1;

    localparam logic [COORD_W:0]   H_RES_W      = CW1'(H_RES);
    localparam logic [COORD_W:0]   H_SYNC_BEG_W = CW1'(H_RES + H_FP);
    localparam logic [COORD_W:0]   H_SYNC_END_W = CW1'(H_RES + H_FP + H_SYNC);
    localparam logic [COORD_W:0]   H_TOTAL_W    = CW1'(H_TOTAL);
    localparam logic [COORD_W:0]   V_RES_W      = CW1'(V_RES);
    localparam logic [COORD_W:0]   V_SYNC_BEG_W = CW1'(V_RES + V_FP);
    localparam logic [COORD_W:0]   V_SYNC_END_W = CW1'(V_RES + V_FP + V_SYNC);
    localparam logic [COORD_W:0]   LEAD_W       = CW1'(FETCH_LEAD);
    localparam logic [COORD_W-1:0] H_LAST       = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST       = COORD_W'(V_TOTAL - 1);
    localparam logic               HPOL         = VIDEO_MODE.h_sync_pol;
    localparam logic               VPOL         = VIDEO_MODE.v_sync_pol;

    // Elaboration-time guards on the parameter set.
    if (H_TOTAL > (1 << COORD_W)) begin : g_bad_h_total
        $error("video_timing_gen: H_TOTAL does not fit in COORD_W bits");
    end
    if (V_TOTAL > (1 << COORD_W)) begin : g_bad_v_total
        $error("video_timing_gen: V_TOTAL does not fit in COORD_W bits");
    end
    if ((FETCH_LEAD < 0) || (FETCH_LEAD >= H_RES)) begin : g_bad_lead
        $error("video_timing_gen: FETCH_LEAD must lie in 0..h_res-1");
    end

    logic [COORD_W-1:0] r_h_cnt;
    logic [COORD_W-1:0] r_v_cnt;

    logic               r_hsync;
    logic               r_vsync;
    logic               r_de;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_line_start;
    logic               r_frame_start;
    logic               r_fetch_valid;
    logic [COORD_W-1:0] r_fetch_x;
    logic [COORD_W-1:0] r_fetch_y;

    logic [COORD_W:0]   w_h;
    logic [COORD_W:0]   w_v;
    logic               w_h_last;
    logic [COORD_W-1:0] w_v_next;
    logic               w_de;
    logic               w_hs_act;
    logic               w_vs_act;
    logic [COORD_W:0]   w_lead_sum;
    logic               w_lead_wrap;
    logic [COORD_W-1:0] w_fetch_h;
    logic [COORD_W-1:0] w_fetch_v;
    logic               w_fetch_act;

    assign w_h      = {1'b0, r_h_cnt};
    assign w_v      = {1'b0, r_v_cnt};
    assign w_h_last = (r_h_cnt == H_LAST);
    // Row that follows the current one, wrapping at the bottom of the frame.
    assign w_v_next = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + COORD_W'(1);

    assign w_de     = (w_h < H_RES_W) && (w_v < V_RES_W);
    assign w_hs_act = (w_h >= H_SYNC_BEG_W) && (w_h < H_SYNC_END_W);
    // vsync is decided on v_cnt alone, so its edges line up with h_cnt=0.
    assign w_vs_act = (w_v >= V_SYNC_BEG_W) && (w_v < V_SYNC_END_W);

    // Lead point: FETCH_LEAD < h_res <= H_TOTAL, so at most one wrap into
    // the next row is possible and a single compare/subtract resolves it.
    assign w_lead_sum  = w_h + LEAD_W;
    assign w_lead_wrap = (w_lead_sum >= H_TOTAL_W);
    assign w_fetch_h   = w_lead_wrap ? COORD_W'(w_lead_sum - H_TOTAL_W)
                                     : w_lead_sum[COORD_W-1:0];
    assign w_fetch_v   = w_lead_wrap ? w_v_next : r_v_cnt;
    assign w_fetch_act = ({1'b0, w_fetch_h} < H_RES_W) && ({1'b0, w_fetch_v} < V_RES_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_hsync       <= ~HPOL;
            r_vsync       <= ~VPOL;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fetch_x     <= '0;
            r_fetch_y     <= '0;
        end else if (en) begin
            r_h_cnt <= w_h_last ? '0 : r_h_cnt + COORD_W'(1);
            if (w_h_last) begin
                r_v_cnt <= w_v_next;
            end

            r_hsync       <= w_hs_act ? HPOL : ~HPOL;
            r_vsync       <= w_vs_act ? VPOL : ~VPOL;
            r_de          <= w_de;
            r_x           <= w_de ? r_h_cnt : '0;
            r_y           <= w_de ? r_v_cnt : '0;
            r_line_start  <= w_de && (r_h_cnt == '0);
            r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
            r_fetch_valid <= w_fetch_act;
            r_fetch_x     <= w_fetch_act ? w_fetch_h : '0;
            r_fetch_y     <= w_fetch_act ? w_fetch_v : '0;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign fetch_valid = r_fetch_valid;
    assign fetch_x     = r_fetch_x;
    assign fetch_y     = r_fetch_y;

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//
// Five instances share clk/rst/en:
//   A  small mode, negative syncs, COORD_W=4 (H_TOTAL=15), FETCH_LEAD=2
//   B  small mode, positive syncs, zero h back porch, H_TOTAL=16=2^COORD_W,
//      FETCH_LEAD=h_res-1
//   C  same mode as A, COORD_W=8, FETCH_LEAD=0
//   D  VMODE_800x600p60, default COORD_W/FETCH_LEAD
//   E  all defaults (640x480p60)
// The reference model maps "number of enabled cycles since reset" to a raster
// position with division/modulo over the frame and derives every output from
// the mode description. D and E are modelled from literal mode values kept
// here, independent of the package.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_video_timing_gen;
    import video_modes_pkg::*;

    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        line_start;
        logic        frame_start;
        logic        fetch_valid;
        logic [11:0] fetch_x;
        logic [11:0] fetch_y;
    } out_t;

    localparam int W = $bits(out_t);

    typedef struct {
        logic rst;
        logic en;
        out_t exp;
    } vec_t;

    localparam video_mode_t MODE_A = '{
        clock_config: '{pclk_khz: 32'd1000},
        h_res: 16'd8, h_fp: 16'd2, h_sync: 16'd3, h_bp: 16'd2,
        v_res: 16'd5, v_fp: 16'd1, v_sync: 16'd2, v_bp: 16'd1,
        h_sync_pol: 1'b0, v_sync_pol: 1'b0
    };
    localparam video_mode_t MODE_B = '{
        clock_config: '{pclk_khz: 32'd1000},
        h_res: 16'd10, h_fp: 16'd2, h_sync: 16'd4, h_bp: 16'd0,
        v_res: 16'd4,  v_fp: 16'd0, v_sync: 16'd1, v_bp: 16'd2,
        h_sync_pol: 1'b1, v_sync_pol: 1'b1
    };
    localparam video_mode_t MODE_800 = '{
        clock_config: '{pclk_khz: 32'd40000},
        h_res: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
        v_res: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23,
        h_sync_pol: 1'b1, v_sync_pol: 1'b1
    };
    localparam video_mode_t MODE_640 = '{
        clock_config: '{pclk_khz: 32'd25175},
        h_res: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
        v_res: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33,
        h_sync_pol: 1'b0, v_sync_pol: 1'b0
    };

    // ---------------------------------------------------------------- clock/reset
    logic clk;
    logic rst;
    logic en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- DUTs
    logic       hs_a, vs_a, de_a, ls_a, fs_a, fv_a;
    logic [3:0] x_a, y_a, fx_a, fy_a;
    logic       hs_b, vs_b, de_b, ls_b, fs_b, fv_b;
    logic [3:0] x_b, y_b, fx_b, fy_b;
    logic       hs_c, vs_c, de_c, ls_c, fs_c, fv_c;
    logic [7:0] x_c, y_c, fx_c, fy_c;
    logic        hs_d, vs_d, de_d, ls_d, fs_d, fv_d;
    logic [11:0] x_d, y_d, fx_d, fy_d;
    logic        hs_e, vs_e, de_e, ls_e, fs_e, fv_e;
    logic [11:0] x_e, y_e, fx_e, fy_e;

    video_timing_gen #(.VIDEO_MODE(MODE_A), .COORD_W(4), .FETCH_LEAD(2)) u_a (
        .clk(clk), .rst(rst), .en(en), .hsync(hs_a), .vsync(vs_a), .de(de_a),
        .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a),
        .fetch_valid(fv_a), .fetch_x(fx_a), .fetch_y(fy_a));

    video_timing_gen #(.VIDEO_MODE(MODE_B), .COORD_W(4), .FETCH_LEAD(9)) u_b (
        .clk(clk), .rst(rst), .en(en), .hsync(hs_b), .vsync(vs_b), .de(de_b),
        .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b),
        .fetch_valid(fv_b), .fetch_x(fx_b), .fetch_y(fy_b));

    video_timing_gen #(.VIDEO_MODE(MODE_A), .COORD_W(8), .FETCH_LEAD(0)) u_c (
        .clk(clk), .rst(rst), .en(en), .hsync(hs_c), .vsync(vs_c), .de(de_c),
        .x(x_c), .y(y_c), .line_start(ls_c), .frame_start(fs_c),
        .fetch_valid(fv_c), .fetch_x(fx_c), .fetch_y(fy_c));

    video_timing_gen #(.VIDEO_MODE(VMODE_800x600p60)) u_d (
        .clk(clk), .rst(rst), .en(en), .hsync(hs_d), .vsync(vs_d), .de(de_d),
        .x(x_d), .y(y_d), .line_start(ls_d), .frame_start(fs_d),
        .fetch_valid(fv_d), .fetch_x(fx_d), .fetch_y(fy_d));

    video_timing_gen u_e (
        .clk(clk), .rst(rst), .en(en), .hsync(hs_e), .vsync(vs_e), .de(de_e),
        .x(x_e), .y(y_e), .line_start(ls_e), .frame_start(fs_e),
        .fetch_valid(fv_e), .fetch_x(fx_e), .fetch_y(fy_e));

    // ---------------------------------------------------------------- model
    // k = enabled cycles since the last reset; k=0 means reset values.
    function automatic out_t model(input video_mode_t m, input int lead, input longint k);
        out_t   o;
        int     hr, hf, hs, vr, vf, vs, ht, vt, h, v, fh, fv;
        longint ft, p, q;
        o = '0;
        o.hsync = ~m.h_sync_pol;
        o.vsync = ~m.v_sync_pol;
        if (k == 0) return o;
        hr = int'(m.h_res); hf = int'(m.h_fp); hs = int'(m.h_sync);
        vr = int'(m.v_res); vf = int'(m.v_fp); vs = int'(m.v_sync);
        ht = hr + hf + hs + int'(m.h_bp);
        vt = vr + vf + vs + int'(m.v_bp);
        ft = longint'(ht) * vt;
        p  = (k - 1) % ft;
        h  = int'(p % ht);
        v  = int'(p / ht);
        o.de = (h < hr) && (v < vr);
        if (h >= hr + hf && h < hr + hf + hs) o.hsync = m.h_sync_pol;
        if (v >= vr + vf && v < vr + vf + vs) o.vsync = m.v_sync_pol;
        if (o.de) begin
            o.x = 12'(h);
            o.y = 12'(v);
        end
        o.line_start  = o.de && (h == 0);
        o.frame_start = (h == 0) && (v == 0);
        q  = (p + lead) % ft;
        fh = int'(q % ht);
        fv = int'(q / ht);
        o.fetch_valid = (fh < hr) && (fv < vr);
        if (o.fetch_valid) begin
            o.fetch_x = 12'(fh);
            o.fetch_y = 12'(fv);
        end
        return o;
    endfunction

    function automatic out_t pk(input logic hs, input logic vs, input logic d,
                                input logic [11:0] px, input logic [11:0] py,
                                input logic ls, input logic fs, input logic fv,
                                input logic [11:0] fx, input logic [11:0] fy);
        out_t o;
        o = '{hsync: hs, vsync: vs, de: d, x: px, y: py, line_start: ls,
              frame_start: fs, fetch_valid: fv, fetch_x: fx, fetch_y: fy};
        return o;
    endfunction

    // ---------------------------------------------------------------- scoreboard
    int          n_checks = 0;
    int          n_fail   = 0;
    longint      idx      = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input out_t act, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    function automatic out_t act_a();
        return pk(hs_a, vs_a, de_a, 12'(x_a), 12'(y_a), ls_a, fs_a, fv_a, 12'(fx_a), 12'(fy_a));
    endfunction

    task automatic check_all();
        chk("inst_a", act_a(), model(MODE_A, 2, idx));
        chk("inst_b", pk(hs_b, vs_b, de_b, 12'(x_b), 12'(y_b), ls_b, fs_b, fv_b,
                         12'(fx_b), 12'(fy_b)), model(MODE_B, 9, idx));
        chk("inst_c", pk(hs_c, vs_c, de_c, 12'(x_c), 12'(y_c), ls_c, fs_c, fv_c,
                         12'(fx_c), 12'(fy_c)), model(MODE_A, 0, idx));
        chk("inst_d_800", pk(hs_d, vs_d, de_d, x_d, y_d, ls_d, fs_d, fv_d, fx_d, fy_d),
            model(MODE_800, 2, idx));
        chk("inst_e_640", pk(hs_e, vs_e, de_e, x_e, y_e, ls_e, fs_e, fv_e, fx_e, fy_e),
            model(MODE_640, 2, idx));
    endtask

    // ---------------------------------------------------------------- driver
    // Called at a falling edge: drive inputs, take the rising edge, then
    // check everything at the next falling edge.
    task automatic step(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        if (r) idx = 0;
        else if (e) idx++;
        @(negedge clk);
        check_all();
    endtask

    // ---------------------------------------------------------------- test
    vec_t tbl[8];

    initial begin : main
        out_t   got;
        logic   r;
        int     n;
        longint de_cnt, ls_cnt;

        // Mode A, FETCH_LEAD=2: active h 0..7, fp 8..9, sync 10..12, bp 13..14.
        //                    rst   en    hs    vs    de    x  y  ls    fs    fv    fx fy
        tbl[0] = '{1'b1, 1'b0, pk(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0)};
        tbl[1] = '{1'b0, 1'b1, pk(1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 2, 0)};
        tbl[2] = '{1'b0, 1'b1, pk(1'b1, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0, 1'b1, 3, 0)};
        tbl[3] = '{1'b0, 1'b0, pk(1'b1, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0, 1'b1, 3, 0)};
        tbl[4] = '{1'b0, 1'b1, pk(1'b1, 1'b1, 1'b1, 2, 0, 1'b0, 1'b0, 1'b1, 4, 0)};
        tbl[5] = '{1'b1, 1'b1, pk(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0)};
        tbl[6] = '{1'b0, 1'b0, pk(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0)};
        tbl[7] = '{1'b0, 1'b1, pk(1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 2, 0)};

        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);

        // Directed vectors on instance A through the expected queue.
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(tbl[i].exp);
            step(tbl[i].rst, tbl[i].en);
            got = act_a();
            chk($sformatf("table_%0d", i), got, out_t'(exp_q.pop_front()));
        end

        // Continuous run: several small frames, first line of 800x600 incl.
        // hsync at h_cnt=840, and the 640x480 line wrap at column 800.
        for (int i = 0; i < 1300; i++) step(1'b0, 1'b1);

        // Random enable with rare resets.
        for (int i = 0; i < 2500; i++) begin
            r = ($urandom_range(0, 599) == 0);
            step(r, 1'(($urandom_range(0, 1))));
        end

        // Mid-frame reset on instance A at (x=3, y=2), then one full frame.
        n = 0;
        while (!(idx > 0 && ((idx - 1) % 135) == 33) && n < 1000) begin
            step(1'b0, 1'b1);
            n++;
        end
        chk_int("reach_mid_frame", longint'(x_a), 3);
        step(1'b1, 1'b1);
        chk_int("rst_de_low", longint'(de_a), 0);
        step(1'b0, 1'b1);
        chk_int("post_rst_frame_start", longint'(fs_a), 1);
        de_cnt = longint'(de_a);
        ls_cnt = longint'(ls_a);
        n = 0;
        while (n < 500) begin
            step(1'b0, 1'b1);
            n++;
            if (fs_a) break;
            de_cnt += longint'(de_a);
            ls_cnt += longint'(ls_a);
        end
        chk_int("frame_period", n, (8 + 2 + 3 + 2) * (5 + 1 + 2 + 1));
        chk_int("de_per_frame", de_cnt, 8 * 5);
        chk_int("line_start_per_frame", ls_cnt, 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
